// File: rtl/snn_image_loader.sv
// Byte-stream image loader for the SNN core: unpacks packed pixels into the
// input-unit RAM, starts the core, and returns the classified digit as ASCII.
module snn_image_loader #(
   parameter int NUM_PIXELS = 784,
   parameter int ADDR_W     = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_d,
   output logic              ram_we,
   input  logic [ADDR_W-1:0] core_addr,
   output logic              core_start,
   input  logic              core_done,
   input  logic [3:0]        core_digit,
   output logic [7:0]        res_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic [7:0]        img_cnt
);

   localparam logic [2:0] S_LOAD   = 3'd0;
   localparam logic [2:0] S_UNPACK = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_REPORT = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

   logic [2:0]        state;
   logic [7:0]        shreg;
   logic [2:0]        bit_cnt;
   logic [ADDR_W-1:0] pix_addr;
   logic [3:0]        digit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_LOAD;
         shreg    <= '0;
         bit_cnt  <= '0;
         pix_addr <= '0;
         digit    <= '0;
         img_cnt  <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (rx_valid) begin
                  shreg   <= rx_data;
                  bit_cnt <= '0;
                  state   <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               shreg   <= {1'b0, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
               // Hold the address on the final pixel so it never runs past the image.
               if (!(bit_cnt == 3'd7 && pix_addr == LAST_PIX))
                  pix_addr <= pix_addr + 1'b1;
               if (bit_cnt == 3'd7)
                  state <= (pix_addr == LAST_PIX) ? S_START : S_LOAD;
            end
            S_START: begin
               pix_addr <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  digit <= core_digit;
                  state <= S_REPORT;
               end
            end
            S_REPORT: begin
               if (res_ready) begin
                  img_cnt <= img_cnt + 8'd1;
                  state   <= S_LOAD;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

   assign rx_ready   = (state == S_LOAD);
   assign busy       = (state != S_LOAD);
   assign ram_we     = (state == S_UNPACK);
   assign ram_d      = shreg[0];
   assign core_start = (state == S_START);
   assign res_valid  = (state == S_REPORT);
   // The core owns the address port from START until the result is taken.
   assign ram_addr   = (state == S_LOAD || state == S_UNPACK) ? pix_addr : core_addr;
   assign res_data   = (digit > 4'd9) ? 8'h3F : (8'h30 + {4'h0, digit});

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed bench for snn_image_loader: a full-size instance for load/report
// behaviour and a one-byte-image instance for the image counter wrap.
module tb_snn_image_loader;

   logic       clk = 1'b0;
   logic       rst;
   always #5 clk = ~clk;

   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic [9:0] ram_addr, core_addr;
   logic       ram_d, ram_we, core_start, core_done;
   logic [3:0] core_digit;
   logic [7:0] res_data, img_cnt;
   logic       res_valid, res_ready, busy;

   logic [7:0] rx_data2;
   logic       rx_valid2, rx_ready2;
   logic [9:0] ram_addr2, core_addr2;
   logic       ram_d2, ram_we2, core_start2, core_done2;
   logic [3:0] core_digit2;
   logic [7:0] res_data2, img_cnt2;
   logic       res_valid2, res_ready2, busy2;

   snn_image_loader #(.NUM_PIXELS(784), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .core_addr(core_addr),
      .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .img_cnt(img_cnt));

   snn_image_loader #(.NUM_PIXELS(8), .ADDR_W(10)) dut2 (
      .clk(clk), .rst(rst), .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
      .ram_addr(ram_addr2), .ram_d(ram_d2), .ram_we(ram_we2), .core_addr(core_addr2),
      .core_start(core_start2), .core_done(core_done2), .core_digit(core_digit2),
      .res_data(res_data2), .res_valid(res_valid2), .res_ready(res_ready2),
      .busy(busy2), .img_cnt(img_cnt2));

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int start_cnt = 0;
   int last_start_cyc = 0;
   int wr_addr_q[$];
   bit wr_dat_q[$];
   int wr_cyc_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (ram_we) begin
         wr_addr_q.push_back(int'(ram_addr));
         wr_dat_q.push_back(ram_d);
         wr_cyc_q.push_back(cyc);
      end
      if (core_start) begin
         start_cnt++;
         last_start_cyc = cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 40) begin
         step;
         n++;
      end
      if (!rx_ready) begin
         tests++; fails++;
         $display("FAIL send_byte timeout: rx_ready=%b required 1", rx_ready);
      end
      step;
      rx_valid = 1'b0;
   endtask

   task automatic wait_start;
      int n;
      n = 0;
      while (!core_start && n < 30) begin
         step;
         n++;
      end
      tests++;
      if (core_start !== 1'b1) begin
         fails++;
         $display("FAIL core_start timeout: got %b required 1", core_start);
      end
      step;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step; step;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step;
         tests += 4;
         if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset rx_ready: got %b required 1", rx_ready); end
         if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b required 0", busy); end
         if (ram_we !== 1'b0) begin fails++; $display("FAIL reset ram_we: got %b required 0", ram_we); end
         if (core_start !== 1'b0) begin fails++; $display("FAIL reset core_start: got %b required 0", core_start); end
      end
      tests += 5;
      if (img_cnt !== 8'd0) begin fails++; $display("FAIL reset img_cnt: got %0d required 0", img_cnt); end
      if (res_data !== 8'h30) begin fails++; $display("FAIL reset res_data: got %h required 30", res_data); end
      if (res_valid !== 1'b0) begin fails++; $display("FAIL reset res_valid: got %b required 0", res_valid); end
      if (ram_addr !== 10'd0) begin fails++; $display("FAIL reset ram_addr: got %0d required 0", ram_addr); end
      if (start_cnt !== 0) begin fails++; $display("FAIL reset start_cnt: got %0d required 0", start_cnt); end
   endtask

   task automatic test_first_byte;
      int base, n, bad_addr;
      logic [7:0] obs;
      base = wr_addr_q.size();
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      step;
      rx_data = 8'h00;
      n = 0;
      while (!rx_ready && n < 20) begin
         n++;
         step;
      end
      rx_valid = 1'b0;
      tests += 4;
      if (n !== 8) begin fails++; $display("FAIL first_byte ready_low_cycles: got %0d required 8", n); end
      if (wr_addr_q.size() - base !== 8) begin
         fails++; $display("FAIL first_byte write_count: got %0d required 8", wr_addr_q.size() - base);
      end else begin
         obs = '0;
         bad_addr = 0;
         for (int i = 0; i < 8; i++) begin
            obs[i] = wr_dat_q[base + i];
            if (wr_addr_q[base + i] != i) bad_addr++;
         end
         if (obs !== 8'hA5) begin fails++; $display("FAIL first_byte data: got %h required a5", obs); end
         if (bad_addr !== 0) begin fails++; $display("FAIL first_byte addr: got %0d bad required 0", bad_addr); end
      end
   endtask

   task automatic test_full_image;
      int base, s0, gaps, ones, last;
      rst = 1'b1;
      step;
      rst = 1'b0;
      step;
      base = wr_addr_q.size();
      s0 = start_cnt;
      for (int k = 0; k < 98; k++) send_byte(8'hFF);
      wait_start;
      gaps = 0;
      ones = 0;
      tests += 5;
      if (wr_addr_q.size() - base !== 784) begin
         fails++; $display("FAIL full_image write_count: got %0d required 784", wr_addr_q.size() - base);
      end else begin
         for (int i = 0; i < 784; i++) begin
            if (wr_addr_q[base + i] != i) gaps++;
            if (wr_dat_q[base + i]) ones++;
         end
         last = wr_cyc_q[base + 783];
         if (gaps !== 0) begin fails++; $display("FAIL full_image addr_gaps: got %0d required 0", gaps); end
         if (ones !== 784) begin fails++; $display("FAIL full_image ones: got %0d required 784", ones); end
         if (last_start_cyc !== last + 1) begin
            fails++; $display("FAIL full_image start_cycle: got %0d required %0d", last_start_cyc, last + 1);
         end
      end
      if (start_cnt - s0 !== 1) begin fails++; $display("FAIL full_image start_pulses: got %0d required 1", start_cnt - s0); end
      core_addr = 10'd123;
      #1;
      tests += 5;
      if (ram_addr !== 10'd123) begin fails++; $display("FAIL wait ram_addr: got %0d required 123", ram_addr); end
      core_addr = 10'd700;
      #1;
      if (ram_addr !== 10'd700) begin fails++; $display("FAIL wait ram_addr: got %0d required 700", ram_addr); end
      if (ram_we !== 1'b0) begin fails++; $display("FAIL wait ram_we: got %b required 0", ram_we); end
      if (busy !== 1'b1) begin fails++; $display("FAIL wait busy: got %b required 1", busy); end
      if (core_start !== 1'b0) begin fails++; $display("FAIL wait core_start: got %b required 0", core_start); end
   endtask

   task automatic test_report_hold;
      res_ready  = 1'b0;
      core_digit = 4'd7;
      core_done  = 1'b1;
      step;
      core_done  = 1'b0;
      core_digit = 4'hF;
      for (int i = 0; i < 5; i++) begin
         tests += 3;
         if (res_valid !== 1'b1) begin fails++; $display("FAIL report res_valid: got %b required 1", res_valid); end
         if (res_data !== 8'h37) begin fails++; $display("FAIL report res_data: got %h required 37", res_data); end
         if (img_cnt !== 8'd0) begin fails++; $display("FAIL report img_cnt: got %0d required 0", img_cnt); end
         if (i < 4) step;
      end
      res_ready = 1'b1;
      step;
      res_ready = 1'b0;
      tests += 4;
      if (img_cnt !== 8'd1) begin fails++; $display("FAIL report img_cnt_after: got %0d required 1", img_cnt); end
      if (rx_ready !== 1'b1) begin fails++; $display("FAIL report rx_ready_after: got %b required 1", rx_ready); end
      if (busy !== 1'b0) begin fails++; $display("FAIL report busy_after: got %b required 0", busy); end
      if (res_valid !== 1'b0) begin fails++; $display("FAIL report res_valid_after: got %b required 0", res_valid); end
      core_digit = 4'd5;
      core_done  = 1'b1;
      step;
      core_done  = 1'b0;
      tests += 3;
      if (busy !== 1'b0) begin fails++; $display("FAIL ignore_done busy: got %b required 0", busy); end
      if (res_valid !== 1'b0) begin fails++; $display("FAIL ignore_done res_valid: got %b required 0", res_valid); end
      if (res_data !== 8'h37) begin fails++; $display("FAIL ignore_done res_data: got %h required 37", res_data); end
   endtask

   task automatic test_digit_twelve;
      int base, bad;
      logic [7:0] kb;
      base = wr_addr_q.size();
      for (int k = 0; k < 98; k++) send_byte(8'(k));
      wait_start;
      res_ready  = 1'b1;
      core_digit = 4'd12;
      core_done  = 1'b1;
      step;
      core_done  = 1'b0;
      tests += 2;
      if (res_valid !== 1'b1) begin fails++; $display("FAIL digit12 res_valid: got %b required 1", res_valid); end
      if (res_data !== 8'h3F) begin fails++; $display("FAIL digit12 res_data: got %h required 3f", res_data); end
      step;
      res_ready = 1'b0;
      tests += 4;
      if (img_cnt !== 8'd2) begin fails++; $display("FAIL digit12 img_cnt: got %0d required 2", img_cnt); end
      if (res_valid !== 1'b0) begin fails++; $display("FAIL digit12 res_valid_after: got %b required 0", res_valid); end
      if (rx_ready !== 1'b1) begin fails++; $display("FAIL digit12 rx_ready_after: got %b required 1", rx_ready); end
      bad = 0;
      if (wr_addr_q.size() - base == 784) begin
         for (int i = 0; i < 784; i++) begin
            kb = 8'(i / 8);
            if (wr_dat_q[base + i] !== kb[i % 8] || wr_addr_q[base + i] != i) bad++;
         end
      end else bad = -1;
      if (bad !== 0) begin fails++; $display("FAIL digit12 pixel_data: got %0d bad required 0", bad); end
   endtask

   task automatic test_reset_mid;
      int base, s0, gaps;
      for (int k = 0; k < 50; k++) send_byte(8'h5A);
      rst = 1'b1;
      #1;
      tests += 6;
      if (rx_ready !== 1'b1) begin fails++; $display("FAIL midreset rx_ready: got %b required 1", rx_ready); end
      if (busy !== 1'b0) begin fails++; $display("FAIL midreset busy: got %b required 0", busy); end
      if (ram_we !== 1'b0) begin fails++; $display("FAIL midreset ram_we: got %b required 0", ram_we); end
      if (ram_addr !== 10'd0) begin fails++; $display("FAIL midreset ram_addr: got %0d required 0", ram_addr); end
      if (img_cnt !== 8'd0) begin fails++; $display("FAIL midreset img_cnt: got %0d required 0", img_cnt); end
      if (res_data !== 8'h30) begin fails++; $display("FAIL midreset res_data: got %h required 30", res_data); end
      step;
      rst = 1'b0;
      step;
      base = wr_addr_q.size();
      s0 = start_cnt;
      for (int k = 0; k < 97; k++) send_byte(8'h3C);
      for (int i = 0; i < 12; i++) step;
      tests += 1;
      if (start_cnt - s0 !== 0) begin fails++; $display("FAIL midreset early_start: got %0d required 0", start_cnt - s0); end
      send_byte(8'h3C);
      wait_start;
      tests += 3;
      if (start_cnt - s0 !== 1) begin fails++; $display("FAIL midreset start_pulses: got %0d required 1", start_cnt - s0); end
      if (wr_addr_q.size() - base !== 784) begin
         fails++; $display("FAIL midreset write_count: got %0d required 784", wr_addr_q.size() - base);
      end else begin
         gaps = 0;
         for (int i = 0; i < 784; i++) if (wr_addr_q[base + i] != i) gaps++;
         if (wr_addr_q[base] !== 0 || gaps !== 0) begin
            fails++; $display("FAIL midreset first_addr: got %0d (gaps %0d) required 0", wr_addr_q[base], gaps);
         end
      end
   endtask

   task automatic test_wrap;
      int n;
      logic [3:0] d;
      logic [7:0] exp_c;
      for (int i = 0; i < 256; i++) begin
         rx_data2  = 8'(i);
         rx_valid2 = 1'b1;
         n = 0;
         while (!rx_ready2 && n < 30) begin step; n++; end
         step;
         rx_valid2 = 1'b0;
         n = 0;
         while (!core_start2 && n < 30) begin step; n++; end
         step;
         d = 4'(i);
         exp_c = (d > 4'd9) ? 8'h3F : (8'h30 + 8'(d));
         core_digit2 = d;
         core_done2  = 1'b1;
         res_ready2  = 1'b1;
         step;
         core_done2 = 1'b0;
         tests++;
         if (res_valid2 !== 1'b1 || res_data2 !== exp_c) begin
            fails++; $display("FAIL wrap res_data img %0d: got %h valid %b required %h", i, res_data2, res_valid2, exp_c);
         end
         step;
         res_ready2 = 1'b0;
         if (i == 254) begin
            tests++;
            if (img_cnt2 !== 8'd255) begin fails++; $display("FAIL wrap img_cnt: got %0d required 255", img_cnt2); end
         end
      end
      tests++;
      if (img_cnt2 !== 8'd0) begin fails++; $display("FAIL wrap img_cnt_wrapped: got %0d required 0", img_cnt2); end
   endtask

   initial begin
      rst = 1'b0;
      rx_data = '0;  rx_valid = 1'b0;  core_addr = '0;  core_done = 1'b0;
      core_digit = '0;  res_ready = 1'b0;
      rx_data2 = '0; rx_valid2 = 1'b0; core_addr2 = '0; core_done2 = 1'b0;
      core_digit2 = '0; res_ready2 = 1'b0;
      #1;
      test_reset;
      test_first_byte;
      test_full_image;
      test_report_hold;
      test_digit_twelve;
      test_reset_mid;
      test_wrap;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
